// File: rtl/divider_pkg.sv
// Shared definitions for the restoring divider: default width, FSM encoding, counter sizing.
// No logic of its own; imported by the divider and its bench.
// The counter width helper lets a non-default WIDTH still size its counter correctly.
package divider_pkg;

    localparam int DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Bits needed to count 0..w inclusive
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/divider.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// Latency: WIDTH+1 cycles from accepted start to the one-cycle Ready pulse.
// Backpressure: none; start is ignored while Busy, and a start in DONE chains with no gap.
module divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             Busy,
    output logic             Ready,
    output logic             div_zero
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   prem_q, prem_d;     // partial remainder, one spare bit
    logic [WIDTH-1:0] work_q, work_d;     // dividend shifts out, quotient bits shift in
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;

    logic [WIDTH+1:0] prem_shift;
    logic [WIDTH+1:0] trial;
    logic             qbit;
    logic [WIDTH:0]   step_prem;
    logic [WIDTH-1:0] step_work;

    // One restoring step: shift in the next dividend bit, trial-subtract, keep on no borrow.
    // The extra top bit of trial is the borrow; a zero divisor never borrows, giving all-ones
    // quotient and the dividend itself as the remainder.
    always_comb begin
        prem_shift = {prem_q, work_q[WIDTH-1]};
        trial      = prem_shift - {2'b00, dvsr_q};
        qbit       = ~trial[WIDTH+1];
        step_prem  = qbit ? trial[WIDTH:0] : prem_shift[WIDTH:0];
        step_work  = {work_q[WIDTH-2:0], qbit};
    end

    // Next-state and datapath control; every register holds unless its state says otherwise.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        work_d  = work_q;
        dvsr_d  = dvsr_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    prem_d  = '0;
                    work_d  = dividend;
                    dvsr_d  = divisor;
                    dz_d    = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                prem_d = step_prem;
                work_d = step_work;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                    quo_d   = step_work;
                    rem_d   = step_prem[WIDTH-1:0];
                    dz_d    = (dvsr_q == '0);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d  = (state_d == CALC);
        ready_d = (state_d == DONE);
    end

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            work_q  <= '0;
            dvsr_q  <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            work_q  <= work_d;
            dvsr_q  <= dvsr_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign Busy      = busy_q;
    assign Ready     = ready_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for the divider: directed vectors feed a scoreboard queue,
// a negedge monitor pops and compares on every Ready pulse, including latency.
// Timing invariants (no Busy/Ready overlap, single-cycle Ready) are also asserted.
module tb_divider;
    import divider_pkg::*;

    localparam int W   = 16;
    localparam int LAT = W + 1;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         Busy;
    logic         Ready;
    logic         div_zero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           st;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .Busy      (Busy),
        .Ready     (Ready),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge index: value read at a posedge is the number of earlier edges
    always @(posedge clk) cyc <= cyc + 1;

    assert property (@(posedge clk) disable iff (!rst_n) !(Busy && Ready));
    assert property (@(posedge clk) disable iff (!rst_n) Ready |=> !Ready);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Independent reference: plain integer divide, with the zero-divisor convention
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int st);
        exp_t e;
        if (b == 0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end
        e.st = st;
        return e;
    endfunction

    // Monitor: every Ready must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (Busy && Ready) check("busy_ready_overlap", 32'd1, 32'd0);
            if (Ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("quotient",  32'(quotient),  32'(e.q));
                    check("remainder", 32'(remainder), 32'(e.r));
                    check("div_zero",  32'(div_zero),  32'(e.dz));
                    check("latency",   32'(cyc - e.st), 32'(LAT));
                end
            end
        end
    end

    // One-cycle start pulse; expectation is queued only when scoreboarded
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit sb);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        if (sb) exp_q.push_back(model(a, b, cyc));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded wait for the scoreboard to drain
    task automatic drain();
        int i;
        for (i = 0; i < 4 * LAT; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d results outstanding", exp_q.size());
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        check("rst_quotient",  32'(quotient),  32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_busy",      32'(Busy),      32'd0);
        check("rst_ready",     32'(Ready),     32'd0);
        check("rst_div_zero",  32'(div_zero),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Hand-computed vectors
        issue(16'd18874, 16'd256, 1'b1);   // 73 r 186
        check("busy_after_start", 32'(Busy), 32'd1);
        drain();
        issue(16'd1000, 16'd0, 1'b1);      // FFFF r 1000, div_zero
        drain();
        issue(16'd100, 16'd7, 1'b1);       // 14 r 2
        check("div_zero_cleared", 32'(div_zero), 32'd0);
        drain();
        issue(16'd0, 16'd5, 1'b1);         // 0 r 0
        drain();
        issue(16'd65535, 16'd65535, 1'b1); // 1 r 0
        drain();
        issue(16'd1, 16'd65535, 1'b1);     // 0 r 1
        drain();
        issue(16'd12345, 16'd123, 1'b1);   // 100 r 45
        drain();
        issue(16'd65535, 16'd256, 1'b1);   // 255 r 255
        drain();

        // Start held high: three chained operations, each accepted 17 edges apart
        @(negedge clk);
        start    = 1'b1;
        dividend = 16'd100;
        divisor  = 16'd7;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            exp_q.push_back(model(16'd100, 16'd7, cyc));
            if (k < 2) repeat (LAT - 1) @(posedge clk);
        end
        @(negedge clk);
        start = 1'b0;
        drain();

        // A start during CALC with different operands must be ignored
        issue(16'd18874, 16'd256, 1'b1);
        repeat (4) @(negedge clk);
        issue(16'd500, 16'd3, 1'b0);
        drain();

        // Reset at the eighth CALC cycle aborts the operation
        issue(16'd40000, 16'd3, 1'b0);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy",      32'(Busy),      32'd0);
        check("abort_ready",     32'(Ready),     32'd0);
        check("abort_quotient",  32'(quotient),  32'd0);
        check("abort_remainder", 32'(remainder), 32'd0);
        check("abort_div_zero",  32'(div_zero),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * LAT) @(negedge clk);
        issue(16'd65535, 16'd1, 1'b1);     // 65535 r 0
        drain();

        // Short random sweep with corner operands mixed in
        for (int i = 0; i < 48; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = W'($urandom);
            case (i % 8)
                0: a = '0;
                1: b = 16'd1;
                2: a = '1;
                3: b = '1;
                4: b = '0;
                5: b = W'($urandom_range(1, 15));
                default: ;
            endcase
            issue(a, b, 1'b1);
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
